// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side pointer, status and data-out controller of an async FIFO
// All state is in rclk; rq2_wptr reaches outputs only through registers.
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     rclk,
    input  logic                     sw_rst,
    input  logic                     read_enable,
    input  logic [ADDRESS_WIDTH-1:0] aempty_value,
    input  logic [ADDRESS_WIDTH:0]   rq2_wptr,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic [ADDRESS_WIDTH-1:0] raddr,
    output logic                     mem_ren,
    output logic [ADDRESS_WIDTH:0]   rptr,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     rdata_valid,
    output logic                     rempty,
    output logic                     rd_almost_empty,
    output logic                     underflow,
    output logic [ADDRESS_WIDTH:0]   fifo_read_count,
    output logic [ADDRESS_WIDTH:0]   rd_level
);
    localparam int AW = ADDRESS_WIDTH;

    logic [AW:0]           rbin_q, rbin_d, rptr_q, rptr_d, lvl_q, lvl_d, wbin;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q, rempty_q, raempty_q, underflow_q, rd_fire;

    assign rd_fire = read_enable & ~rempty_q;
    assign rbin_d  = rbin_q + {{AW{1'b0}}, rd_fire};
    assign rptr_d  = rbin_d ^ (rbin_d >> 1);
    assign lvl_d   = wbin - rbin_d;

    // Gray to binary: each bit is the XOR of itself and all higher Gray bits
    always_comb begin
        wbin = '0;
        for (int i = 0; i <= AW; i++) wbin[i] = ^(rq2_wptr >> i);
    end

    always_ff @(posedge rclk) begin
        if (sw_rst) begin
            rbin_q      <= '0;
            rptr_q      <= '0;
            lvl_q       <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            rempty_q    <= 1'b1;
            raempty_q   <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            rbin_q      <= rbin_d;
            rptr_q      <= rptr_d;
            lvl_q       <= lvl_d;
            rdata_q     <= rd_fire ? mem_rdata : rdata_q;
            rvalid_q    <= rd_fire;
            rempty_q    <= (rptr_d == rq2_wptr);
            raempty_q   <= (lvl_d <= {1'b0, aempty_value});
            underflow_q <= read_enable & rempty_q;
        end
    end

    assign raddr           = rbin_q[AW-1:0];
    assign mem_ren         = rd_fire;
    assign rptr            = rptr_q;
    assign rdata           = rdata_q;
    assign rdata_valid     = rvalid_q;
    assign rempty          = rempty_q;
    assign rd_almost_empty = raempty_q;
    assign underflow       = underflow_q;
    assign fifo_read_count = rbin_q;
    assign rd_level        = lvl_q;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed scenario bench for the FIFO read controller
module tb_fifo_rd_ctrl;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          rclk = 1'b0;
    logic          sw_rst, read_enable;
    logic [AW-1:0] aempty_value;
    logic [AW:0]   rq2_wptr;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] raddr;
    logic          mem_ren, rdata_valid, rempty, rd_almost_empty, underflow;
    logic [AW:0]   rptr, fifo_read_count, rd_level;
    logic [DW-1:0] rdata;

    int checks = 0;
    int errors = 0;

    fifo_rd_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .rclk(rclk), .sw_rst(sw_rst), .read_enable(read_enable),
        .aempty_value(aempty_value), .rq2_wptr(rq2_wptr), .mem_rdata(mem_rdata),
        .raddr(raddr), .mem_ren(mem_ren), .rptr(rptr), .rdata(rdata),
        .rdata_valid(rdata_valid), .rempty(rempty), .rd_almost_empty(rd_almost_empty),
        .underflow(underflow), .fifo_read_count(fifo_read_count), .rd_level(rd_level)
    );

    always #5 rclk = ~rclk;

    // Memory model: asynchronous read, content tagged with its address
    assign mem_rdata = {16'hA5A5, 11'd0, raddr};

    function automatic logic [AW:0] gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [DW-1:0] mem_at(input logic [AW-1:0] a);
        return {16'hA5A5, 11'd0, a};
    endfunction

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        checks++;
        if ({rempty, rd_almost_empty, underflow, rdata_valid} !== 4'b1100) begin
            errors++;
            $display("FAIL %s flags: got %b expected 1100", tag, {rempty, rd_almost_empty, underflow, rdata_valid});
        end
        checks++;
        if ({rptr, rd_level, fifo_read_count} !== '0) begin
            errors++;
            $display("FAIL %s ptrs: rptr=%0d level=%0d count=%0d expected 0", tag, rptr, rd_level, fifo_read_count);
        end
        checks++;
        if (rdata !== '0) begin
            errors++;
            $display("FAIL %s rdata: got %0h expected 0", tag, rdata);
        end
    endtask

    // Publishes a new write pointer then reads until empty (bounded)
    task automatic drain_to(input logic [AW:0] target);
        rq2_wptr = gray(target);
        read_enable = 1'b0;
        tick();
        read_enable = 1'b1;
        for (int n = 0; n < 40 && !rempty; n++) tick();
        read_enable = 1'b0;
        checks++;
        if (fifo_read_count !== target || rempty !== 1'b1) begin
            errors++;
            $display("FAIL drain_to: count=%0d empty=%b expected count=%0d empty=1", fifo_read_count, rempty, target);
        end
    endtask

    task automatic test_reset();
        sw_rst = 1'b1; read_enable = 1'b0; aempty_value = 5'd2; rq2_wptr = '0;
        tick();
        tick();
        chk_reset_state("reset");
        sw_rst = 1'b0;
    endtask

    task automatic test_underflow();
        read_enable = 1'b1;
        #1;
        chk("underflow mem_ren", mem_ren, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (underflow !== 1'b1 || raddr !== 0 || rdata_valid !== 1'b0 || fifo_read_count !== 0) begin
                errors++;
                $display("FAIL underflow cycle %0d: uf=%b raddr=%0d valid=%b count=%0d expected 1,0,0,0",
                         i, underflow, raddr, rdata_valid, fifo_read_count);
            end
        end
        read_enable = 1'b0;
        tick();
        chk("underflow clear", underflow, 0);
    endtask

    task automatic test_drain();
        rq2_wptr = 6'd6;
        aempty_value = 5'd2;
        tick();
        chk("drain rempty", rempty, 0);
        chk("drain level", rd_level, 4);
        chk("drain aempty", rd_almost_empty, 0);
        read_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain raddr", raddr, i);
            chk("drain mem_ren", mem_ren, 1);
            tick();
            chk("drain level step", rd_level, 3 - i);
            chk("drain aempty step", rd_almost_empty, (3 - i) <= 2);
            chk("drain valid", rdata_valid, 1);
            chk("drain rdata", rdata, mem_at(i[AW-1:0]));
            chk("drain rempty step", rempty, i == 3);
        end
        read_enable = 1'b0;
        tick();
        chk("drain valid end", rdata_valid, 0);
        chk("drain rdata hold", rdata, mem_at(5'd3));
    endtask

    task automatic test_wrap();
        drain_to(6'd36);
        drain_to(6'd62);
        rq2_wptr = gray(6'd2);
        tick();
        chk("wrap level", rd_level, 4);
        chk("wrap rempty0", rempty, 0);
        read_enable = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        read_enable = 1'b0;
        chk("wrap count", fifo_read_count, 2);
        chk("wrap rptr", rptr, 3);
        chk("wrap rempty", rempty, 1);
        chk("wrap level0", rd_level, 0);
    endtask

    task automatic test_reset_mid_op();
        rq2_wptr = gray(6'd7);
        tick();
        chk("midrst level", rd_level, 5);
        read_enable = 1'b1;
        sw_rst = 1'b1;
        tick();
        chk_reset_state("midrst");
        sw_rst = 1'b0;
        read_enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        rq2_wptr = gray(6'd1);
        tick();
        chk("simul level pre", rd_level, 1);
        chk("simul rempty pre", rempty, 0);
        read_enable = 1'b1;
        rq2_wptr = gray(6'd2);
        tick();
        read_enable = 1'b0;
        chk("simul rempty", rempty, 0);
        chk("simul level", rd_level, 1);
        chk("simul valid", rdata_valid, 1);
        chk("simul rdata", rdata, mem_at(5'd0));
        chk("simul count", fifo_read_count, 1);
    endtask

    initial begin
        test_reset();
        test_underflow();
        test_drain();
        test_wrap();
        test_reset_mid_op();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
